mux_scan_n: RTL
===============

MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 Parameter N_CH, default 8, number of input channels; legal range 2..64.
REQ-002 Parameter W, default 1, bit width of each channel.
REQ-003 Parameter SELW, default $clog2(N_CH), select and channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  block enable; 0 freezes all state and holds y.
REQ-007 mode  input  1  0 = DIRECT (channel from sel), 1 = SCAN (internal round-robin).
REQ-008 sel  input  SELW  channel index in DIRECT mode.
REQ-009 dwell  input  8  extra cycles each channel is held in SCAN mode (0 = advance every cycle).
REQ-010 d  input  N_CH*W  packed channel data; channel k occupies d[k*W +: W].
REQ-011 y  output  W  registered selected data.
REQ-012 ch  output  SELW  index of the channel currently driving y.
REQ-013 upd  output  1  one-cycle pulse when y was loaded from a different channel than on the previous load.
REQ-014 err  output  1  registered; high while DIRECT mode is active with sel >= N_CH.

Function
REQ-015 States: IDLE, DIRECT, SCAN, held in a state register.
REQ-016 Transitions: en=0 -> IDLE from any state; en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN; evaluated every cycle.
REQ-017 IDLE: y, ch, the scan counter and the dwell counter hold; upd=0; err=0.
REQ-018 DIRECT, sel < N_CH: y <= d[sel], ch <= sel; latency exactly one clock from sel/d to y.
REQ-019 DIRECT, sel >= N_CH: y and ch hold; err=1 in the following cycle; upd=0.
REQ-020 SCAN entry from IDLE or DIRECT: scan index and dwell counter clear to 0; the first load is channel 0 in the entry cycle.
REQ-021 SCAN: y <= d[scan index] every cycle, so data changes on the current channel propagate with one-cycle latency.
REQ-022 SCAN: the dwell counter increments each cycle; when it equals dwell, it clears and the scan index advances.
REQ-023 Scan index wraps from N_CH-1 to 0; N_CH that is not a power of two never produces index >= N_CH.
REQ-024 A dwell change mid-scan takes effect on the next compare; if the counter already exceeds the new dwell, advance occurs on the next cycle.
REQ-025 upd=1 exactly one cycle after a load whose ch differs from the preceding loaded ch, including the first load after reset when ch != 0.
REQ-026 A mode change has no empty cycle: the load in the switching cycle follows the new mode.
REQ-027 en deassert during SCAN followed by reassert restarts at channel 0 (REQ-020); y holds across the gap.

Reset
REQ-028 rst_n=0 asynchronously forces: state=IDLE, y=0, ch=0, upd=0, err=0, scan index=0, dwell counter=0.
REQ-029 Release is synchronous to clk; the first active edge after release evaluates REQ-016 normally.
REQ-030 Reset mid-scan discards progress; no output carries pre-reset values after release.

Structure
REQ-031 Shared package mux_pkg holds the state enumeration (IDLE/DIRECT/SCAN), mode encodings, and the DWELL_W=8 constant.
REQ-032 Sub-module mux_dwell_cnt holds the dwell counter and the scan index with wrap; it outputs the index and an advance strobe.
REQ-033 The top level holds the state register, the data select, the y/ch/upd/err registers, and err decode.

Verification
REQ-034 N_CH=8, W=4, DIRECT, sel=5, d ch5=0xA -> y=0xA, ch=5 one clock later; upd=1 for one cycle.
REQ-035 SCAN, dwell=2 -> ch sequence 0,0,0,1,1,1,...,7,7,7,0 (3 cycles each, wrap to 0); upd pulses at each change.
REQ-036 N_CH=6, DIRECT, sel=7 -> y/ch unchanged, err=1; then sel=2 -> err=0, y=d ch2.
REQ-037 SCAN at ch=4, en=0 for 5 cycles then 1 -> y held during the gap; restart at ch=0.
REQ-038 rst_n low mid-scan (ch=3) between clock edges -> y=0, ch=0, upd=0 immediately; after release with en=1, SCAN begins at 0.
REQ-039 N_CH=5, SCAN, dwell=0 -> ch 0,1,2,3,4,0 on consecutive cycles; never 5..7.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the scanning channel multiplexer: FSM states, mode encodings
// and the dwell counter width.
package mux_pkg;

  localparam int DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Next state depends only on the live controls, never on the current state.
  function automatic state_t next_state_f(input logic en, input logic mode);
    if (!en) begin
      return IDLE;
    end else if (mode == MODE_SCAN) begin
      return SCAN;
    end else begin
      return DIRECT;
    end
  endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// Round-robin scan index with a per-channel dwell counter. idx is the channel
// to load this cycle; adv is high when this cycle's load is the last on idx.
module mux_dwell_cnt
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               restart,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SELW-1:0]    idx,
  output logic               adv
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(N_CH - 1);

  logic [SELW-1:0]    idx_reg;
  logic [SELW-1:0]    idx_next;
  logic [DWELL_W-1:0] cnt_reg;
  logic [DWELL_W-1:0] cnt_next;
  logic [DWELL_W-1:0] cnt_cur;

  // A restart behaves as if both registers were already zero this cycle, so the
  // entry cycle itself loads channel 0 and counts toward its dwell.
  always_comb begin
    idx      = restart ? '0 : idx_reg;
    cnt_cur  = restart ? '0 : cnt_reg;
    adv      = run && (cnt_cur >= dwell);
    idx_next = idx_reg;
    cnt_next = cnt_reg;
    if (run) begin
      if (adv) begin
        cnt_next = '0;
        idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt_next = cnt_cur + 1'b1;
        idx_next = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
      cnt_reg <= '0;
    end else begin
      idx_reg <= idx_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with a direct-select mode and a round-robin
// scan mode; reports channel changes (upd) and out-of-range selects (err).
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 1,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [N_CH*W-1:0]   d,
  output logic [W-1:0]        y,
  output logic [SELW-1:0]     ch,
  output logic                upd,
  output logic                err
);

  localparam logic [SELW:0] N_CH_EXT = (SELW + 1)'(N_CH);

  state_t state_reg;
  state_t state_next;

  logic [W-1:0]    chan [N_CH];
  logic [W-1:0]    y_reg;
  logic [SELW-1:0] ch_reg;
  logic            upd_reg;
  logic            err_reg;
  logic            scan_adv_reg;

  logic            sel_bad;
  logic            scan_run;
  logic            scan_restart;
  logic [SELW-1:0] scan_idx;
  logic            scan_adv;
  logic            load;
  logic [SELW-1:0] load_ch;
  logic [W-1:0]    load_data;
  logic            upd_next;
  logic            err_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    assign chan[gi] = d[gi*W +: W];
  end

  mux_dwell_cnt #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_dwell_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (scan_run),
    .restart (scan_restart),
    .dwell   (dwell),
    .idx     (scan_idx),
    .adv     (scan_adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = next_state_f(en, mode);
  end

  // The load is steered by the mode being entered, so a mode switch never
  // costs a cycle; state_reg only tells us whether a scan is just starting.
  always_comb begin
    sel_bad      = {1'b0, sel} >= N_CH_EXT;
    scan_run     = (state_next == SCAN);
    scan_restart = scan_run && (state_reg != SCAN);
    load         = 1'b0;
    load_ch      = ch_reg;
    upd_next     = 1'b0;
    err_next     = 1'b0;
    case (state_next)
      DIRECT: begin
        err_next = sel_bad;
        if (!sel_bad) begin
          load     = 1'b1;
          load_ch  = sel;
          upd_next = (sel != ch_reg);
        end
      end
      SCAN: begin
        load     = 1'b1;
        load_ch  = scan_idx;
        // Mid-scan the channel differs from the last load exactly when the
        // previous cycle advanced the index.
        upd_next = scan_restart ? (ch_reg != '0) : scan_adv_reg;
      end
      default: begin
      end
    endcase
    load_data = chan[load_ch];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg        <= '0;
      ch_reg       <= '0;
      upd_reg      <= 1'b0;
      err_reg      <= 1'b0;
      scan_adv_reg <= 1'b0;
    end else begin
      upd_reg      <= upd_next;
      err_reg      <= err_next;
      scan_adv_reg <= scan_adv;
      if (load) begin
        y_reg  <= load_data;
        ch_reg <= load_ch;
      end
    end
  end

  assign y   = y_reg;
  assign ch  = ch_reg;
  assign upd = upd_reg;
  assign err = err_reg;

endmodule
